// File: rtl/alu_result_mux_sched.sv
// alu_result_mux_sched
//   Round-robin scheduler for the shared 4:1 adiabatic result mux. One requester
//   is granted at a time. The scheduler drives the mux select, sequences the four
//   power-clock phase enables over a HOLD-cycle evaluation window, and captures
//   the mux output. It then inserts one recovery cycle before the next grant.
//
// Ports
//   clk          : single clock, rising-edge
//   rst_n        : asynchronous active-low reset
//   req          : level requests 0..3 (bit i also names mux input i)
//   mux_out      : shared mux output, sampled only at the capture edge
//   sel          : mux select {in1,in0}; changes only on a grant
//   phase        : one-hot {clkneg1,clkneg,clkpos1,clkpos}
//   gnt          : one-hot grant, held for the evaluation window
//   busy         : high in EVAL and RECOVER
//   result       : captured mux output
//   result_valid : one-cycle pulse when result updates
//   result_id    : requester index that owns result
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for any req; arbitrate from ptr on the grant edge
// EVAL    | gnt/sel held, phase steps one-hot by cnt, capture at HOLD-1
// RECOVER | one dead cycle with gnt and phase cleared before next grant

module alu_result_mux_sched #(
  parameter int WIDTH = 16,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  output logic [1:0]       sel,
  output logic [3:0]       phase,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       result_id
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // Final count of the evaluation window; cnt runs 0..HOLD-1.
  localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

  logic [1:0]       state_q,        state_d;
  logic [1:0]       ptr_q,          ptr_d;
  logic [3:0]       cnt_q,          cnt_d;
  logic [1:0]       sel_q,          sel_d;
  logic [3:0]       phase_q,        phase_d;
  logic [3:0]       gnt_q,          gnt_d;
  logic [WIDTH-1:0] result_q,       result_d;
  logic             result_valid_q, result_valid_d;
  logic [1:0]       result_id_q,    result_id_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       scan_idx;
  logic [3:0]       cnt_inc;

  // Rotating-priority search: the first asserted request at ptr, ptr+1, ...
  // The 2-bit index wraps naturally mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    phase_d        = phase_q;
    gnt_d          = gnt_q;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_EVAL;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          cnt_d   = 4'd0;
          ptr_d   = win_idx + 2'd1;
          phase_d = 4'b0001;
        end
      end

      ST_EVAL: begin
        if (cnt_q == CNT_LAST) begin
          // sel_q still holds the winner index for this transaction.
          result_d       = mux_out;
          result_id_d    = sel_q;
          result_valid_d = 1'b1;
          gnt_d          = 4'b0000;
          phase_d        = 4'b0000;
          cnt_d          = 4'd0;
          state_d        = ST_RECOVER;
        end else begin
          cnt_d   = cnt_inc;
          // Phase tracks cnt mod 4, so windows longer than 4 wrap to clkpos.
          phase_d = 4'b0001 << cnt_inc[1:0];
        end
      end

      ST_RECOVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        phase_d = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Phase and grant are registered so the power-clock enables leave flops
  // directly and cannot glitch from decode logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= 2'd0;
      cnt_q          <= 4'd0;
      sel_q          <= 2'd0;
      phase_q        <= 4'b0000;
      gnt_q          <= 4'b0000;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= 2'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      phase_q        <= phase_d;
      gnt_q          <= gnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
    end
  end

  assign sel          = sel_q;
  assign phase        = phase_q;
  assign gnt          = gnt_q;
  assign busy         = (state_q == ST_EVAL) || (state_q == ST_RECOVER);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;

endmodule

// File: tb/tb_alu_result_mux_sched.sv
module tb_alu_result_mux_sched;

  logic clk;
  logic rst_n;

  logic [3:0]  req4,  req1,  req6;
  logic [15:0] mux4,  mux1,  mux6;
  logic [1:0]  sel4,  sel1,  sel6;
  logic [3:0]  ph4,   ph1,   ph6;
  logic [3:0]  gnt4,  gnt1,  gnt6;
  logic        busy4, busy1, busy6;
  logic [15:0] res4,  res1,  res6;
  logic        val4,  val1,  val6;
  logic [1:0]  id4,   id1,   id6;

  int checks = 0;
  int errors = 0;

  // Expected captures, packed as {id[1:0], data[15:0]}.
  logic [17:0] q4[$];
  logic [17:0] q1[$];
  logic [17:0] q6[$];

  alu_result_mux_sched #(.WIDTH(16), .HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .mux_out(mux4),
    .sel(sel4), .phase(ph4), .gnt(gnt4), .busy(busy4),
    .result(res4), .result_valid(val4), .result_id(id4));

  alu_result_mux_sched #(.WIDTH(16), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .mux_out(mux1),
    .sel(sel1), .phase(ph1), .gnt(gnt1), .busy(busy1),
    .result(res1), .result_valid(val1), .result_id(id1));

  alu_result_mux_sched #(.WIDTH(16), .HOLD(6)) u6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .mux_out(mux6),
    .sel(sel6), .phase(ph6), .gnt(gnt6), .busy(busy6),
    .result(res6), .result_valid(val6), .result_id(id6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops: one per result_valid pulse.
  always @(negedge clk) begin
    logic [17:0] e;
    if (val4 === 1'b1) begin
      if (q4.size() == 0) chk("unexpected_valid4", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("sb4_result", 32'(res4), 32'(e[15:0]));
        chk("sb4_id", 32'(id4), 32'(e[17:16]));
      end
    end
    if (val1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_valid1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("sb1_result", 32'(res1), 32'(e[15:0]));
        chk("sb1_id", 32'(id1), 32'(e[17:16]));
      end
    end
    if (val6 === 1'b1) begin
      if (q6.size() == 0) chk("unexpected_valid6", 32'd1, 32'd0);
      else begin
        e = q6.pop_front();
        chk("sb6_result", 32'(res6), 32'(e[15:0]));
        chk("sb6_id", 32'(id6), 32'(e[17:16]));
      end
    end
  end

  initial begin
    logic [3:0] exp_ph;
    logic [1:0] exp_id;

    rst_n = 1'b0;
    req4 = 4'b0; req1 = 4'b0; req6 = 4'b0;
    mux4 = 16'h0; mux1 = 16'h0; mux6 = 16'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel4), 32'd0);
    chk("rst_phase", 32'(ph4), 32'd0);
    chk("rst_gnt", 32'(gnt4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_result", 32'(res4), 32'd0);
    chk("rst_valid", 32'(val4), 32'd0);
    chk("rst_id", 32'(id4), 32'd0);
    rst_n = 1'b1;

    // Single request: c input, HOLD=4
    req4 = 4'b0100;
    mux4 = 16'hBEEF;
    q4.push_back({2'd2, 16'hBEEF});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_ph = 4'(1 << (j % 4));
      chk("single_gnt", 32'(gnt4), 32'h4);
      chk("single_sel", 32'(sel4), 32'd2);
      chk("single_phase", 32'(ph4), 32'(exp_ph));
      chk("single_busy", 32'(busy4), 32'd1);
      chk("single_novalid", 32'(val4), 32'd0);
      if (j == 0) req4 = 4'b0000;
    end
    @(negedge clk);
    chk("single_valid", 32'(val4), 32'd1);
    chk("single_gnt_clr", 32'(gnt4), 32'd0);
    chk("single_phase_clr", 32'(ph4), 32'd0);
    chk("single_recover_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    chk("single_valid_pulse", 32'(val4), 32'd0);
    chk("single_idle_busy", 32'(busy4), 32'd0);
    chk("single_result_hold", 32'(res4), 32'hBEEF);
    chk("single_sel_hold", 32'(sel4), 32'd2);

    // Request drop after one EVAL cycle; mux_out valid only at capture
    req4 = 4'b0010;
    mux4 = 16'h0000;
    q4.push_back({2'd1, 16'h1234});
    @(negedge clk);
    chk("drop_gnt", 32'(gnt4), 32'h2);
    chk("drop_sel", 32'(sel4), 32'd1);
    req4 = 4'b0000;
    repeat (3) @(negedge clk);
    chk("drop_still_busy", 32'(busy4), 32'd1);
    mux4 = 16'h1234;
    @(negedge clk);
    chk("drop_valid", 32'(val4), 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drop_no_regrant", 32'(gnt4), 32'd0);
      chk("drop_idle", 32'(busy4), 32'd0);
    end

    // Reset asserted at cnt=2 of an EVAL window
    req4 = 4'b1000;
    mux4 = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("mid_phase_cnt2", 32'(ph4), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel4), 32'd0);
    chk("mid_rst_gnt", 32'(gnt4), 32'd0);
    chk("mid_rst_phase", 32'(ph4), 32'd0);
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_result", 32'(res4), 32'd0);
    chk("mid_rst_valid", 32'(val4), 32'd0);
    chk("mid_rst_id", 32'(id4), 32'd0);
    req4 = 4'b1111;
    repeat (6) @(negedge clk);
    chk("mid_rst_result_stays", 32'(res4), 32'd0);
    chk("mid_rst_sel_stays", 32'(sel4), 32'd0);
    rst_n = 1'b1;

    // Fairness with req=1111: grants 0,1,2,3,0 every HOLD+2 cycles
    for (int g = 0; g < 5; g++) begin
      exp_id = 2'(g % 4);
      @(negedge clk);
      chk("fair_gnt", 32'(gnt4), 32'(4'b0001 << exp_id));
      chk("fair_sel", 32'(sel4), 32'(exp_id));
      chk("fair_phase", 32'(ph4), 32'h1);
      mux4 = 16'hA000 + 16'(g);
      q4.push_back({exp_id, 16'hA000 + 16'(g)});
      if (g == 4) req4 = 4'b0000;
      repeat (5) @(negedge clk);
      chk("fair_gap_gnt", 32'(gnt4), 32'd0);
      chk("fair_gap_busy", 32'(busy4), 32'd0);
    end

    // HOLD=1: one cycle of clkpos, then capture
    req1 = 4'b0001;
    mux1 = 16'h5A5A;
    q1.push_back({2'd0, 16'h5A5A});
    @(negedge clk);
    chk("h1_gnt", 32'(gnt1), 32'h1);
    chk("h1_phase", 32'(ph1), 32'h1);
    chk("h1_busy", 32'(busy1), 32'd1);
    req1 = 4'b0000;
    @(negedge clk);
    chk("h1_valid", 32'(val1), 32'd1);
    chk("h1_phase_clr", 32'(ph1), 32'd0);
    chk("h1_gnt_clr", 32'(gnt1), 32'd0);
    @(negedge clk);
    chk("h1_valid_pulse", 32'(val1), 32'd0);
    chk("h1_idle", 32'(busy1), 32'd0);

    // HOLD=6: phase wraps after clkneg1
    req6 = 4'b1000;
    mux6 = 16'hC3C3;
    q6.push_back({2'd3, 16'hC3C3});
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      exp_ph = 4'(1 << (j % 4));
      chk("h6_phase", 32'(ph6), 32'(exp_ph));
      chk("h6_gnt", 32'(gnt6), 32'h8);
      chk("h6_novalid", 32'(val6), 32'd0);
      if (j == 0) req6 = 4'b0000;
    end
    @(negedge clk);
    chk("h6_valid", 32'(val6), 32'd1);
    chk("h6_phase_clr", 32'(ph6), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb4_drained", 32'(q4.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb6_drained", 32'(q6.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
